cpu6_pipereg_stage: RTL and testbench

//  Generic valid/ready pipeline stage register for the cpu6 core; replaces the fixed per-field
//  ID/EX, EX/MEM and MEM/WB registers with one parametrised block carrying a packed payload.

---
 rtl/cpu6_pipereg_pkg.sv | 32 +++
 rtl/cpu6_pipereg_slot.sv | 39 +++
 rtl/cpu6_pipereg_stage.sv | 112 +++++++++++
 tb/tb_cpu6_pipereg_stage.sv | 133 +++++++++++++
 4 files changed

// File: rtl/cpu6_pipereg_pkg.sv
// Shared definitions for the cpu6 pipeline stage register.
// Holds the default payload width, the ID/EX payload field layout, the
// occupancy encoding used by the stage control and small helpers.
package cpu6_pipereg_pkg;

  localparam int PIPEREG_WIDTH = 96;
  localparam int PIPEREG_CNT_W = 16;

  // ID/EX payload packing: {ctrl, pc, instr}
  localparam int IDEX_INSTR_LSB = 0;
  localparam int IDEX_PC_LSB    = 32;
  localparam int IDEX_CTRL_LSB  = 64;

  // Occupancy of the two slots; S is only ever valid when M is valid.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic occ_e occ_of(input logic vm, input logic vs);
    if (vs)      return OCC_FULL;
    else if (vm) return OCC_ONE;
    else         return OCC_EMPTY;
  endfunction

  // Number of live entries, used for flush accounting.
  function automatic logic [1:0] occ_count(input logic vm, input logic vs);
    return {1'b0, vm} + {1'b0, vs};
  endfunction

endpackage

// File: rtl/cpu6_pipereg_slot.sv
// One valid + WIDTH data register of the pipeline stage.
// Ports:
//   clk, reset   clock, synchronous active-high reset (clears valid and data)
//   kill         drop the entry; also zeroes data when CLR_ON_FLUSH != 0
//   load         capture d and mark valid
//   drop         mark invalid, data held
//   d            data to load
//   valid, data  registered slot contents
// Priority: reset > kill > load > drop.
module cpu6_pipereg_slot #(
  parameter int WIDTH        = 96,
  parameter bit CLR_ON_FLUSH = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             kill,
  input  logic             load,
  input  logic             drop,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (kill) begin
      valid <= 1'b0;
      if (CLR_ON_FLUSH) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu6_pipereg_stage.sv
// Generic valid/ready pipeline stage register with stall, flush and a
// 2-entry skid (main slot M drives the outputs, skid slot S catches one
// extra entry) so in_ready depends on state only, never on out_ready.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   flush                kill held and incoming entries this cycle (beats stall)
//   stall                freeze: no accept, no emit, contents held
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload
//   stall_cnt, flush_cnt saturating perf counters
// Optional feature macro: CPU6_PIPEREG_PERF_EN enables the perf counters;
// when undefined both counter outputs are tied to zero.
module cpu6_pipereg_stage
  import cpu6_pipereg_pkg::*;
#(
  parameter int WIDTH        = PIPEREG_WIDTH,
  parameter bit CLR_ON_FLUSH = 1'b1,
  parameter int CNT_W        = PIPEREG_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             stall,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic             vm, vs;
  logic [WIDTH-1:0] dm, ds;
  logic             acc, emit;
  logic             m_load, m_drop, m_from_s, s_load, s_drop;
  logic [WIDTH-1:0] m_d;

  assign in_ready  = ~reset & ~vs & ~stall;
  assign out_valid = vm & ~stall & ~flush & ~reset;
  assign out_data  = dm;
  assign acc       = in_valid & in_ready & ~flush;
  assign emit      = out_valid & out_ready;

  // Stall and flush already force acc=emit=0; flush itself goes to the
  // slots as kill, which overrides any load decided here.
  always_comb begin
    m_load   = 1'b0;
    m_drop   = 1'b0;
    m_from_s = 1'b0;
    s_load   = 1'b0;
    s_drop   = 1'b0;
    case (occ_of(vm, vs))
      OCC_EMPTY: m_load = acc;
      OCC_ONE: begin
        if (emit) begin
          m_load = acc;
          m_drop = ~acc;
        end else begin
          s_load = acc;
        end
      end
      OCC_FULL: begin
        // in_ready is low here, so only the skid entry can advance
        if (emit) begin
          m_load   = 1'b1;
          m_from_s = 1'b1;
          s_drop   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign m_d = m_from_s ? ds : in_data;

  cpu6_pipereg_slot #(.WIDTH(WIDTH), .CLR_ON_FLUSH(CLR_ON_FLUSH)) u_slot_m (
    .clk(clk), .reset(reset), .kill(flush), .load(m_load), .drop(m_drop),
    .d(m_d), .valid(vm), .data(dm)
  );

  cpu6_pipereg_slot #(.WIDTH(WIDTH), .CLR_ON_FLUSH(CLR_ON_FLUSH)) u_slot_s (
    .clk(clk), .reset(reset), .kill(flush), .load(s_load), .drop(s_drop),
    .d(in_data), .valid(vs), .data(ds)
  );

`ifdef CPU6_PIPEREG_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic [CNT_W:0]   flush_sum;

  // One extra bit catches overflow so the counter clamps at all-ones.
  assign flush_sum = (CNT_W+1)'(flush_q) + (CNT_W+1)'(occ_count(vm, vs));

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (flush) flush_q <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu6_pipereg_stage.sv
module tb_cpu6_pipereg_stage;
  localparam int W   = 96;
  localparam int CW  = 16;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, flush, stall, in_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic          in_ready, out_valid;
  logic [CW-1:0] stall_cnt, flush_cnt;

  cpu6_pipereg_stage #(.WIDTH(W), .CLR_ON_FLUSH(1'b1), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // Reference model: the stage is a FIFO of at most two entries.
  logic [W-1:0] q[$];
  logic         zflag = 1'b0;  // payload regs known zero and never reloaded
  int           m_stall = 0, m_flush = 0;
  int           dut_emits = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step(input logic r, input logic f, input logic s, input logic iv,
                      input logic [W-1:0] d, input logic ordy);
    logic exp_ir, exp_ov, acc, emit;
    @(negedge clk);
    reset = r; flush = f; stall = s; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    exp_ir = !r && (q.size() < 2) && !s;
    exp_ov = !r && !f && !s && (q.size() > 0);
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid", out_valid, exp_ov);
    if (q.size() > 0) chk("out_data", out_data, q[0]);
    else if (zflag)   chk("out_data_zero", out_data, '0);
`ifdef CPU6_PIPEREG_PERF_EN
    chk("stall_cnt", stall_cnt, W'(m_stall));
    chk("flush_cnt", flush_cnt, W'(m_flush));
`else
    chk("stall_cnt", stall_cnt, '0);
    chk("flush_cnt", flush_cnt, '0);
`endif
    if (out_valid && out_ready) dut_emits++;
    acc  = exp_ir && iv && !f;
    emit = exp_ov && ordy;
    @(posedge clk);
    if (r) begin
      q.delete(); zflag = 1'b1; m_stall = 0; m_flush = 0;
    end else begin
      if (s) m_stall = (m_stall < MAX) ? m_stall + 1 : MAX;
      if (f) begin
        m_flush = (m_flush + q.size() > MAX) ? MAX : m_flush + q.size();
        q.delete(); zflag = 1'b1;
      end else begin
        if (emit) void'(q.pop_front());
        if (acc) begin q.push_back(d); zflag = 1'b0; end
      end
    end
  endtask

  function automatic logic [W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    zflag = 1'b1;

    // reset state
    step(1, 0, 0, 0, '0, 0);
    step(0, 0, 0, 0, '0, 0);

    // stream 0x1..0x8 with out_ready=1
    dut_emits = 0;
    for (int i = 1; i <= 8; i++) step(0, 0, 0, 1, W'(i), 1);
    step(0, 0, 0, 0, '0, 1);
    chk("stream_count", W'(dut_emits), W'(8));

    // fill both slots, then drain in order
    step(0, 0, 0, 1, W'('hA), 0);
    step(0, 0, 0, 1, W'('hB), 0);
    step(0, 0, 0, 1, W'('hE), 0);   // refused: stage full
    step(0, 0, 0, 0, '0, 1);
    step(0, 0, 0, 0, '0, 1);
    step(0, 0, 0, 0, '0, 1);

    // full stage + flush with incoming 0xC
    step(0, 0, 0, 1, W'('hA), 0);
    step(0, 0, 0, 1, W'('hB), 0);
    step(0, 1, 0, 1, W'('hC), 1);
    step(0, 0, 0, 0, '0, 1);
    step(0, 0, 0, 0, '0, 1);

    // stall holding 0xD for 3 cycles
    step(0, 0, 0, 1, W'('hD), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, W'('hF), 1);
    step(0, 0, 0, 0, '0, 1);
    step(0, 0, 0, 0, '0, 1);

    // flush and stall in the same cycle
    step(0, 0, 0, 1, W'('h11), 0);
    step(0, 1, 1, 1, W'('h12), 1);
    step(0, 0, 0, 0, '0, 1);

    // reset mid-stream
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, W'('h20 + i), i == 2);
    step(1, 0, 0, 1, W'('h30), 1);
    step(0, 0, 0, 0, '0, 1);
    step(0, 0, 0, 1, W'('h31), 1);
    step(0, 0, 0, 0, '0, 1);

    // randomized traffic
    for (int i = 0; i < 10000; i++)
      step(($urandom_range(299) == 0), ($urandom_range(19) == 0), ($urandom_range(7) == 0),
           ($urandom_range(9) < 7), rnd_data(), ($urandom_range(9) < 7));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
